// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// The baud tick travels with the bus so RX and TX can share one generator.
interface uart_tx_if;
    logic       i_s_tick;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done_tick;
    logic       o_busy;

    modport master (
        output i_s_tick, i_tx_start, i_data,
        input  o_tx, o_tx_done_tick, o_busy
    );

    modport slave (
        input  i_s_tick, i_tx_start, i_data,
        output o_tx, o_tx_done_tick, o_busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, SB_TICK/16 stop bits.
// Request to line-low latency is one clock; i_tx_start is ignored until the frame ends.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic      i_clock,
    input  logic      i_reset,
    uart_tx_if.slave  tx_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    logic [4:0] r_tick;
    logic [2:0] r_nbit;
    logic [7:0] r_shift;
    logic       r_par;
    logic       r_tx;
    logic       r_done;
    logic       r_busy;

    logic       w_bit_end;
    logic       w_stop_end;
    logic       w_last_bit;
    logic       w_par_bit;

    assign w_bit_end  = tx_if.i_s_tick && (r_tick == 5'd15);
    assign w_stop_end = tx_if.i_s_tick && (r_tick == 5'(SB_TICK - 1));
    assign w_last_bit = (r_nbit == 3'(DBIT - 1));
    // Parity over all data bits including the one finishing on this edge.
    assign w_par_bit  = r_par ^ r_shift[0] ^ (PARITY == 2);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_nbit  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (tx_if.i_tx_start) begin
                        r_shift <= tx_if.i_data;
                        r_tick  <= '0;
                        r_par   <= 1'b0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_nbit  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else if (tx_if.i_s_tick) begin
                        r_tick <= r_tick + 5'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_shift <= r_shift >> 1;
                        r_par   <= r_par ^ r_shift[0];
                        if (w_last_bit) begin
                            if (PARITY != 0) begin
                                r_tx    <= w_par_bit;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_nbit <= r_nbit + 3'd1;
                            r_tx   <= r_shift[1];
                        end
                    end else if (tx_if.i_s_tick) begin
                        r_tick <= r_tick + 5'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else if (tx_if.i_s_tick) begin
                        r_tick <= r_tick + 5'd1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_stop_end) begin
                        r_tick  <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (tx_if.i_s_tick) begin
                        r_tick <= r_tick + 5'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_if.o_tx           = r_tx;
    assign tx_if.o_tx_done_tick = r_done;
    assign tx_if.o_busy         = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, even parity, odd parity, two stop bits) share one stimulus.
// Every frame is compared cycle by cycle against a tick-count model of the ideal line.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       start;
    logic [7:0] data;

    int total_n = 0;
    int bad_n   = 0;
    int period  = 1;
    int phase   = 0;

    logic tx_w   [4];
    logic done_w [4];
    logic busy_w [4];

    always #5 clk = ~clk;

    uart_tx_if bus [4] ();

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            assign bus[g].i_s_tick   = s_tick;
            assign bus[g].i_tx_start = start;
            assign bus[g].i_data     = data;
            assign tx_w[g]   = bus[g].o_tx;
            assign done_w[g] = bus[g].o_tx_done_tick;
            assign busy_w[g] = bus[g].o_busy;
            uart_tx #(
                .DBIT    (8),
                .SB_TICK ((g == 3) ? 32 : 16),
                .PARITY  ((g == 1) ? 1 : ((g == 2) ? 2 : 0))
            ) u_dut (
                .i_clock (clk),
                .i_reset (rst),
                .tx_if   (bus[g])
            );
        end
    endgenerate

    function automatic int par_mode(int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction

    function automatic int sb_ticks(int k);
        return (k == 3) ? 32 : 16;
    endfunction

    function automatic int frame_ticks(int k);
        return 16 * (1 + 8 + ((par_mode(k) != 0) ? 1 : 0)) + sb_ticks(k);
    endfunction

    // Ideal line level once n ticks have elapsed since acceptance.
    function automatic logic exp_line(int k, logic [7:0] d, int n);
        int idx;
        idx = n / 16;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && par_mode(k) == 1) return ^d;
        if (idx == 9 && par_mode(k) == 2) return ~^d;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total_n++;
        if (act != exp) begin
            bad_n++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step(output bit tk);
        s_tick = (phase == 0);
        tk     = s_tick;
        phase  = (phase + 1) % period;
        @(posedge clk);
        #1;
    endtask

    // Sends d and follows instance k to its done pulse; returns with the done cycle current.
    task automatic frame(input int k, input logic [7:0] d, input int poke_at,
                         output int busy_clk, output logic pbit);
        int n, mism, cyc, limit, tot;
        bit tk, done_seen;
        n = 0; mism = 0; cyc = 0; done_seen = 0;
        tot   = frame_ticks(k);
        limit = tot * period + 20;
        busy_clk = 0;
        pbit  = 1'b0;
        phase = 0;
        start = 1'b1;
        data  = d;
        step(tk);
        start = 1'b0;
        data  = 8'($urandom);
        while (cyc < limit) begin
            if (busy_w[k] === 1'b1) busy_clk++;
            if (tx_w[k]   !== exp_line(k, d, n)) mism++;
            if (busy_w[k] !== (n < tot))         mism++;
            if (done_w[k] !== (n == tot))        mism++;
            if (n == 16 * 9 + 8) pbit = tx_w[k];
            if (n == tot) begin
                done_seen = 1'b1;
                break;
            end
            if (cyc == poke_at) begin
                start = 1'b1;
                data  = 8'h3C;
            end
            step(tk);
            start = 1'b0;
            if (tk) n++;
            cyc++;
        end
        chk($sformatf("done_reached_k%0d_d%02h", k, d), int'(done_seen), 1);
        chk($sformatf("waveform_mismatches_k%0d_d%02h", k, d), mism, 0);
    endtask

    task automatic wait_idle();
        bit tk;
        int cnt;
        cnt = 0;
        while ((busy_w[0] | busy_w[1] | busy_w[2] | busy_w[3]) !== 1'b0 && cnt < 3000) begin
            step(tk);
            cnt++;
        end
        chk("all_idle_wait", int'(cnt < 3000), 1);
    endtask

    typedef struct {
        int         k;
        logic [7:0] d;
        int         per;
        int         exp_clk;
        logic       exp_pbit;
    } vec_t;

    vec_t vt [6];

    initial begin
        int   bc;
        logic pb;
        bit   tk;
        int   k;
        logic [7:0] d;

        vt[0] = '{k: 0, d: 8'hA5, per: 1, exp_clk: 160, exp_pbit: 1'b1};
        vt[1] = '{k: 0, d: 8'h00, per: 4, exp_clk: 640, exp_pbit: 1'b1};
        vt[2] = '{k: 1, d: 8'h07, per: 1, exp_clk: 176, exp_pbit: 1'b1};
        vt[3] = '{k: 2, d: 8'h07, per: 1, exp_clk: 176, exp_pbit: 1'b0};
        vt[4] = '{k: 3, d: 8'hFF, per: 1, exp_clk: 176, exp_pbit: 1'b1};
        vt[5] = '{k: 2, d: 8'h5A, per: 2, exp_clk: 352, exp_pbit: 1'b1};

        rst = 1'b1; s_tick = 1'b0; start = 1'b0; data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_tx_k%0d", i),   int'(tx_w[i]),   1);
            chk($sformatf("reset_busy_k%0d", i), int'(busy_w[i]), 0);
            chk($sformatf("reset_done_k%0d", i), int'(done_w[i]), 0);
        end
        rst = 1'b0;
        repeat (3) step(tk);

        for (int i = 0; i < 6; i++) begin
            period = vt[i].per;
            frame(vt[i].k, vt[i].d, -1, bc, pb);
            chk($sformatf("vec%0d_busy_clocks", i), bc, vt[i].exp_clk);
            chk($sformatf("vec%0d_parity_slot", i), int'(pb), int'(vt[i].exp_pbit));
            wait_idle();
        end

        for (int i = 0; i < 8; i++) begin
            k      = int'($urandom_range(0, 3));
            d      = 8'($urandom);
            period = int'($urandom_range(1, 3));
            frame(k, d, -1, bc, pb);
            chk($sformatf("rand%0d_busy_clocks", i), bc, frame_ticks(k) * period);
            chk($sformatf("rand%0d_parity_slot", i), int'(pb), int'(exp_line(k, d, 16 * 9 + 8)));
            wait_idle();
        end

        // Start mid-frame is ignored; start during the done cycle chains the next frame.
        period = 1;
        frame(0, 8'h81, 50, bc, pb);
        chk("ignored_start_busy_clocks", bc, 160);
        frame(0, 8'h3C, -1, bc, pb);
        chk("back_to_back_busy_clocks", bc, 160);
        wait_idle();

        // Asynchronous reset during data bit 3 of 0xF0.
        phase = 0; start = 1'b1; data = 8'hF0;
        step(tk);
        start = 1'b0;
        repeat (16 * 4 + 5) step(tk);
        chk("pre_reset_bit3_low", int'(tx_w[0]), 0);
        chk("pre_reset_busy", int'(busy_w[0]), 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("async_reset_tx_k%0d", i),   int'(tx_w[i]),   1);
            chk($sformatf("async_reset_busy_k%0d", i), int'(busy_w[i]), 0);
            chk($sformatf("async_reset_done_k%0d", i), int'(done_w[i]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(tk);
        frame(0, 8'h55, -1, bc, pb);
        chk("post_reset_busy_clocks", bc, 160);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 by default, with optional parity.
- Takes a parallel byte over a start/done handshake and shifts it out LSB first on a single line.
- Bit timing comes from the shared baud-rate generator's oversampling tick (16 ticks per bit).
- Sits on the TX side of the UART, next to the receiver, driven by the same i_s_tick.

Parameters:
- DBIT, 8, data bits per frame (legal 5..8).
- SB_TICK, 16, ticks spent in the stop state: 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- i_clock  input  1  system clock; all flops on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_s_tick  input  1  one-cycle oversampling tick from the baud generator (16 per bit).
- i_tx_start  input  1  request to send; sampled only in IDLE.
- i_data  input  8  byte to send; bits [DBIT-1:0] are used.
- o_tx  output  1  serial line; registered; idle level is 1.
- o_tx_done_tick  output  1  one-cycle pulse when the stop period completes.
- o_busy  output  1  high from start acceptance until the frame ends.

Behaviour:
- Reset (async, any time, including mid-frame):
  - State goes to IDLE; tick counter, bit counter, shift register and parity flop are cleared.
  - o_tx=1, o_tx_done_tick=0, o_busy=0.
  - A partial frame is abandoned; the line returns high immediately.
- State register plus registered next-state logic; all outputs come from flops, so there are no combinational glitches on o_tx.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1.
  - On the edge where i_tx_start=1:
    - latch i_data into the shift register;
    - clear the tick counter;
    - go to START, set o_tx=0 and o_busy=1 on that same edge (one-cycle latency from request to line low).
  - i_tx_start while not in IDLE is ignored, and i_data changes after acceptance have no effect.
- Bit-end rule: a bit ends on an edge where i_s_tick=1 and the tick counter equals 15. Otherwise, the counter increments on each edge with i_s_tick=1 and holds when i_s_tick=0.
- START: at bit end:
  - clear the tick counter and bit counter;
  - drive o_tx = shift[0];
  - go to DATA.
- DATA: at bit end:
  - shift right and clear the tick counter;
  - accumulate the parity of the sent bit;
  - if bit counter == DBIT-1:
    - go to PARITY with o_tx = parity bit when PARITY != 0 (even: XOR of data bits; odd: inverted XOR);
    - otherwise go to STOP with o_tx=1;
  - else increment the bit counter and drive o_tx = next shift[0].
- PARITY: at bit end, clear the tick counter, go to STOP, drive o_tx=1.
- STOP:
  - o_tx=1.
  - On an edge with i_s_tick=1 and tick counter == SB_TICK-1: go to IDLE, pulse o_tx_done_tick for exactly one cycle, drop o_busy on the same edge.
- Back-to-back frames: i_tx_start=1 in the cycle where o_tx_done_tick=1 is accepted (state is already IDLE). The next START begins on the following edge with no extra idle time.
- Widths:
  - tick counter is 5 bits (supports SB_TICK up to 32);
  - bit counter is 3 bits;
  - counters never wrap within a frame.
- i_s_tick held high continuously is legal: each clock then counts as one tick.
- Frame length in ticks: 16·(1 + DBIT + (PARITY != 0)) + SB_TICK.

Test Plan:
- Basic frame: DBIT=8, PARITY=0, i_s_tick=1 every cycle, i_data=0xA5, pulse i_tx_start.
  - o_tx low for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then high for 16.
  - o_tx_done_tick pulses at cycle 160 after acceptance; o_busy is high for exactly 160 cycles.
- Slow tick: i_s_tick every 4th cycle, i_data=0x00.
  - Each bit lasts 64 clocks; the frame is 640 clocks; o_tx changes only on tick edges.
- Parity:
  - PARITY=1 (even), i_data=0x07: the parity bit is 1.
  - PARITY=2 (odd), same data: the parity bit is 0.
  - In both cases the frame is 176 ticks and the stop bit is high.
- Start while busy and back-to-back:
  - Assert i_tx_start with 0x3C mid-frame of 0x81: it is ignored and 0x81 is sent intact.
  - Assert i_tx_start with 0x3C in the o_tx_done_tick cycle: o_tx goes low on the next edge and 0x3C is sent.
- Reset mid-frame: assert i_reset during DATA bit 3.
  - o_tx=1, o_busy=0, o_tx_done_tick=0 immediately, without waiting for a clock edge.
  - After release, a new frame with 0x55 transmits correctly from START.
- SB_TICK=32: i_data=0xFF.
  - The stop period is 32 ticks high; o_tx_done_tick pulses at tick 176.
